// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: waits for a host start pulse, then answers with an ack
// and a 40-bit frame {data, checksum}, driving the bus open-drain.
module dht11_responder #(
  parameter int START_MIN    = 900000,
  parameter int WAIT_RELEASE = 1000,
  parameter int ACK_LOW      = 4000,
  parameter int ACK_HIGH     = 4000,
  parameter int BIT_LOW      = 2500,
  parameter int ZERO_HIGH    = 1350,
  parameter int ONE_HIGH     = 3500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dht_bus_in,
  input  logic        load,
  input  logic [31:0] data_in,
  output logic        dht_drive_low,
  output logic        busy,
  output logic        done,
  output logic [3:0]  db_estado
);
  localparam int CW = 20;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_HOST_LOW = 4'd1;
  localparam logic [3:0] S_WAIT     = 4'd2;
  localparam logic [3:0] S_ACK_LOW  = 4'd3;
  localparam logic [3:0] S_ACK_HIGH = 4'd4;
  localparam logic [3:0] S_BIT_LOW  = 4'd5;
  localparam logic [3:0] S_BIT_HIGH = 4'd6;
  localparam logic [3:0] S_END_LOW  = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  logic          sync1_q, sync2_q;
  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    idx_q, idx_d;
  logic [39:0]   snap_q, snap_d;
  logic [31:0]   hold_q;
  logic [7:0]    chk_sum;
  logic          bus_lo, cnt_zero;

  assign bus_lo   = ~sync2_q;
  assign cnt_zero = (cnt_q == '0);
  assign chk_sum  = hold_q[31:24] + hold_q[23:16] + hold_q[15:8] + hold_q[7:0];

  // Outputs decode straight from state so an async reset releases the bus at once.
  assign dht_drive_low = (state_q == S_ACK_LOW) || (state_q == S_BIT_LOW) ||
                         (state_q == S_END_LOW);
  assign busy      = (state_q >= S_ACK_LOW) && (state_q <= S_END_LOW);
  assign done      = (state_q == S_DONE);
  assign db_estado = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hold_q  <= '0;
    end else begin
      sync1_q <= dht_bus_in;
      sync2_q <= sync1_q;
      if (load) hold_q <= data_in;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - CW'(1);
    idx_d   = idx_q;
    snap_d  = snap_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus_lo) state_d = S_HOST_LOW;
      end
      S_HOST_LOW: begin
        // Up-count here only: saturating measure of the host low time.
        cnt_d = cnt_q;
        if (bus_lo) begin
          if (cnt_q < CW'(START_MIN)) cnt_d = cnt_q + CW'(1);
        end else if (cnt_q >= CW'(START_MIN)) begin
          state_d = S_WAIT;
          cnt_d   = CW'(WAIT_RELEASE - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus_lo) begin
          state_d = S_HOST_LOW;
          cnt_d   = '0;
        end else if (cnt_zero) begin
          state_d = S_ACK_LOW;
          cnt_d   = CW'(ACK_LOW - 1);
          snap_d  = {hold_q, chk_sum};
        end
      end
      S_ACK_LOW: if (cnt_zero) begin
        state_d = S_ACK_HIGH;
        cnt_d   = CW'(ACK_HIGH - 1);
        idx_d   = 6'd39;
      end
      S_ACK_HIGH: if (cnt_zero) begin
        state_d = S_BIT_LOW;
        cnt_d   = CW'(BIT_LOW - 1);
      end
      S_BIT_LOW: if (cnt_zero) begin
        state_d = S_BIT_HIGH;
        cnt_d   = snap_q[idx_q] ? CW'(ONE_HIGH - 1) : CW'(ZERO_HIGH - 1);
      end
      S_BIT_HIGH: if (cnt_zero) begin
        state_d = (idx_q != 6'd0) ? S_BIT_LOW : S_END_LOW;
        cnt_d   = CW'(BIT_LOW - 1);
        if (idx_q != 6'd0) idx_d = idx_q - 6'd1;
      end
      S_END_LOW: if (cnt_zero) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end
endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: host model on a wired-AND bus, scoreboard of
// expected frames, and a monitor that decodes the DUT's bus waveform.
module tb_dht11_responder;
  localparam int START_MIN    = 200;
  localparam int WAIT_RELEASE = 20;
  localparam int ACK_LOW      = 40;
  localparam int ACK_HIGH     = 40;
  localparam int BIT_LOW      = 25;
  localparam int ZERO_HIGH    = 13;
  localparam int ONE_HIGH     = 35;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        host_low = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data_in = '0;
  logic        dht_drive_low, busy, done;
  logic [3:0]  db_estado;
  logic        dht_bus_in;

  int checks = 0;
  int failures = 0;
  logic [39:0] exp_q[$];

  assign dht_bus_in = ~(host_low | dht_drive_low);

  always #10 clock = ~clock;

  dht11_responder #(
    .START_MIN(START_MIN), .WAIT_RELEASE(WAIT_RELEASE), .ACK_LOW(ACK_LOW),
    .ACK_HIGH(ACK_HIGH), .BIT_LOW(BIT_LOW), .ZERO_HIGH(ZERO_HIGH), .ONE_HIGH(ONE_HIGH)
  ) dut (
    .clock(clock), .reset(reset), .dht_bus_in(dht_bus_in), .load(load),
    .data_in(data_in), .dht_drive_low(dht_drive_low), .busy(busy), .done(done),
    .db_estado(db_estado)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: run-length decode of dht_drive_low, compare frame on done.
  logic        prev_drv;
  int          run, phase, nb;
  logic [39:0] word;
  logic        bitv;
  always @(negedge clock) begin
    if (reset) begin
      prev_drv = 1'b0; run = 0; phase = 0; nb = 0; word = '0;
    end else begin
      if (dht_drive_low !== prev_drv) begin
        if (prev_drv) begin
          if (phase == 0) begin
            chk("ack_low_len", run, ACK_LOW); phase = 1;
          end else if (phase == 2 && nb == 40) begin
            chk("end_low_len", run, BIT_LOW); phase = 3;
          end else if (phase == 2) begin
            chk("bit_low_len", run, BIT_LOW);
          end
        end else if (phase == 1) begin
          chk("ack_high_len", run, ACK_HIGH); phase = 2; nb = 0;
        end else if (phase == 2) begin
          bitv = (run > (ZERO_HIGH + ONE_HIGH) / 2);
          chk("bit_high_len", run, bitv ? ONE_HIGH : ZERO_HIGH);
          word = {word[38:0], bitv};
          nb++;
        end
        prev_drv = dht_drive_low;
        run = 1;
      end else begin
        run++;
      end
      if (done) begin
        chk("done_phase", phase, 3);
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("frame_word", word, exp_q.pop_front());
        phase = 0;
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic do_load(input logic [31:0] v);
    step(); data_in = v; load = 1'b1;
    step(); load = 1'b0;
  endtask

  task automatic host_pulse(input int len, output logic saw);
    saw = 1'b0;
    host_low = 1'b1;
    repeat (len) begin step(); saw |= dht_drive_low; end
    host_low = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 10000) begin step(); n++; end
    chk("done_timeout", n < 10000, 1);
    chk("busy_at_done", busy, 0);
    repeat (10) step();
    chk("idle_after_frame", db_estado, 0);
  endtask

  task automatic wait_entry(input logic [3:0] st, input int cnt);
    int seen = 0, cyc = 0;
    logic [3:0] pv = db_estado;
    while (seen < cnt && cyc < 10000) begin
      step();
      if (db_estado == st && pv != st) seen++;
      pv = db_estado;
      cyc++;
    end
    chk("entry_timeout", seen, cnt);
  endtask

  initial begin
    logic saw;
    int   lat;
    repeat (3) step();
    chk("rst_drive", dht_drive_low, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", db_estado, 0);
    reset = 1'b0;
    repeat (3) step();

    // Basic frame plus response latency: 2 sync flops + HOST_LOW exit cycle + WAIT.
    do_load(32'h12342202);
    exp_q.push_back(40'h123422026A);
    host_pulse(START_MIN + 10, saw);
    lat = 0;
    while (!dht_drive_low && lat < 200) begin step(); lat++; end
    chk("ack_latency", lat, WAIT_RELEASE + 3);
    wait_done();

    // Second value, mixed bit pattern.
    do_load(32'h2345AAB2);
    exp_q.push_back(40'h2345AAB2C4);
    host_pulse(START_MIN + 10, saw);
    wait_done();

    // Short start is ignored, then a valid one is answered.
    host_pulse(START_MIN / 2, saw);
    repeat (3 * WAIT_RELEASE) begin step(); saw |= dht_drive_low; end
    chk("short_no_drive", saw, 0);
    chk("short_idle", db_estado, 0);
    exp_q.push_back(40'h2345AAB2C4);
    host_pulse(START_MIN + 10, saw);
    wait_done();

    // Load mid-frame affects only the next frame.
    do_load(32'h12342202);
    exp_q.push_back(40'h123422026A);
    host_pulse(START_MIN + 10, saw);
    wait_entry(4'd5, 10);
    chk("busy_mid_frame", busy, 1);
    do_load(32'hFFFFFFFF);
    wait_done();
    exp_q.push_back(40'hFFFFFFFFFC);
    host_pulse(START_MIN + 10, saw);
    wait_done();

    // Reset mid-frame during BIT_HIGH of bit 20.
    host_pulse(START_MIN + 10, saw);
    wait_entry(4'd6, 20);
    step();
    reset = 1'b1;
    #1;
    chk("midrst_drive", dht_drive_low, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_state", db_estado, 0);
    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();
    exp_q.push_back(40'h0000000000);
    host_pulse(START_MIN + 10, saw);
    wait_done();

    // Restart during WAIT: exactly one frame, after the second release.
    do_load(32'h12342202);
    exp_q.push_back(40'h123422026A);
    host_pulse(START_MIN + 10, saw);
    repeat (5) begin step(); saw |= dht_drive_low; end
    chk("wait_gap_no_drive", saw, 0);
    host_pulse(START_MIN + 10, saw);
    chk("restart_no_drive", saw, 0);
    wait_done();
    repeat (400) step();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
